// File: rtl/pipo_pkg.sv
// Shared constants for the pipo parallel-in parallel-out staging register.
package pipo_pkg;
    localparam int PIPO_DEFAULT_WIDTH = 4;
endpackage : pipo_pkg

// File: rtl/pipo.sv
// pipo: WIDTH-bit register retiming a bus by one clock, synchronous active-high reset.
// Define PIPO_ASSERT_EN to compile in simulation-only self-checks (no effect on logic).
module pipo
    import pipo_pkg::*;
#(
    parameter int                 WIDTH   = PIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout
);

    logic [WIDTH-1:0] q_q;

    // NOTE: non-blocking assignment keeps every register update on the same edge-ordered semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= pin;
        end
    end

    assign pout = q_q;

`ifdef PIPO_ASSERT_EN
    // Capture what the register saw at each edge, then compare mid-cycle.
    logic             chk_armed_q;
    logic             chk_rst_q;
    logic [WIDTH-1:0] chk_pin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_armed_q <= 1'b1;
        end
        chk_rst_q <= rst;
        chk_pin_q <= pin;
    end

    always @(negedge clk) begin
        if (chk_armed_q === 1'b1) begin
            if ($isunknown(pout)) begin
                $error("pipo: pout has X/Z after reset at time %0t", $time);
            end else if (chk_rst_q === 1'b1 && pout !== RST_VAL) begin
                $error("pipo: pout=%h expected reset value %h at time %0t", pout, RST_VAL, $time);
            end else if (chk_rst_q === 1'b0 && pout !== chk_pin_q) begin
                $error("pipo: pout=%h expected sampled pin %h at time %0t", pout, chk_pin_q, $time);
            end
        end
    end
`endif

endmodule : pipo

// File: tb/tb_pipo.sv
// Self-checking bench for pipo: directed vector table, glitch/reset sequences,
// an 8-bit parameterised instance, and randomized traffic against a reference model.
module tb_pipo;

    logic       clk;
    logic       rst;
    logic [3:0] pin;
    logic [3:0] pout;

    logic       rst8;
    logic [7:0] pin8;
    logic [7:0] pout8;

    int checks   = 0;
    int failures = 0;

    pipo dut (
        .clk  (clk),
        .rst  (rst),
        .pin  (pin),
        .pout (pout)
    );

    pipo #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .pin  (pin8),
        .pout (pout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] pin;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs just after an edge, then sample 1ns after the next edge.
    task automatic step(input logic r, input logic [3:0] p);
        rst = r;
        pin = p;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] model_q;
    logic [3:0] held;

    initial begin
        rst  = 1'b1;
        pin  = 4'hF;
        rst8 = 1'b1;
        pin8 = 8'hFF;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, "reset_hold0"};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, "reset_hold1"};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0000, "reset_hold2"};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0001, "stream0"};
        vecs[4]  = '{1'b0, 4'b0010, 4'b0010, "stream1"};
        vecs[5]  = '{1'b0, 4'b0011, 4'b0011, "stream2"};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, "stream3"};
        vecs[7]  = '{1'b0, 4'b1000, 4'b1000, "stream4"};
        vecs[8]  = '{1'b0, 4'b1010, 4'b1010, "stream5"};
        vecs[9]  = '{1'b0, 4'b1001, 4'b1001, "stream6"};
        vecs[10] = '{1'b0, 4'b1100, 4'b1100, "stream7"};
        vecs[11] = '{1'b0, 4'b1010, 4'b1010, "pre_midrst"};
        vecs[12] = '{1'b1, 4'b1001, 4'b0000, "mid_reset"};
        vecs[13] = '{1'b0, 4'b1100, 4'b1100, "reset_release"};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].pin);
            check(vecs[i].name, {4'h0, pout}, {4'h0, vecs[i].exp});
        end

        // Output must hold steady between edges.
        #3;
        check("hold_mid_cycle", {4'h0, pout}, 8'h0C);

        // Glitching pin between edges; only the value stable at the edge counts.
        rst = 1'b0;
        held = pout;
        for (int i = 0; i < 4; i++) begin
            pin = (i % 2 == 0) ? 4'b0101 : 4'b1010;
            #1;
        end
        check("glitch_no_effect", {4'h0, pout}, {4'h0, held});
        pin = 4'b0110;
        @(posedge clk);
        #1;
        check("glitch_capture", {4'h0, pout}, 8'h06);
        pin = 4'b0101;
        #2;
        pin = 4'b1010;
        #1;
        check("glitch_hold", {4'h0, pout}, 8'h06);

        // Parameterised instance: WIDTH=8, RST_VAL=A5.
        rst8 = 1'b1;
        pin8 = 8'hFF;
        @(posedge clk);
        #1;
        check("w8_reset", pout8, 8'hA5);
        rst8 = 1'b0;
        pin8 = 8'h3C;
        @(posedge clk);
        #1;
        check("w8_capture", pout8, 8'h3C);
        rst8 = 1'b1;
        pin8 = 8'h00;
        @(posedge clk);
        #1;
        check("w8_rst_midstream", pout8, 8'hA5);

        // Randomized traffic: output after each edge is RST_VAL on reset, else that edge's pin.
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [3:0] p;
            logic [7:0] p8;
            r  = ($urandom_range(0, 7) == 0);
            p  = 4'($urandom);
            p8 = 8'($urandom);
            model_q = r ? 4'h0 : p;
            rst8 = ($urandom_range(0, 5) == 0);
            pin8 = p8;
            step(r, p);
            check("rand_w4", {4'h0, pout}, {4'h0, model_q});
            check("rand_w8", pout8, rst8 ? 8'hA5 : p8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipo

// File: doc/pipo.md
# pipo

Parallel-in parallel-out register: captures a WIDTH-bit parallel input word on every rising clock edge and presents it on a parallel output. It is a generic datapath staging element. It is used wherever a bus must be retimed by exactly one clock cycle with a known reset value.

## Interface
Parameters:
- WIDTH, default 4, data width in bits; legal values are 1 or greater.
- RST_VAL, default 0 (WIDTH bits), value loaded into the register by reset.

Ports:
- clk  input  1  clock; all state updates occur on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- pin  input  WIDTH  parallel data input.
- pout  output  WIDTH  parallel data output, driven directly from the register.

Clocking and reset:
- One clock.
- Reset is synchronous and active-high.

## Operation
- The block holds a single WIDTH-bit register, q, and pout = q at all times.
- At each rising edge of clk:
  - if rst = 1, q <= RST_VAL;
  - otherwise q <= pin.
- There is no enable and no hold mode. The register reloads on every clock edge.
- pout has no combinational path from pin or rst. pout changes only at clock edges.
- Width rules:
  - pin is captured bit-for-bit with no arithmetic, truncation or extension.
  - RST_VAL is exactly WIDTH bits.
- The reset value after power-up is RST_VAL once the first edge with rst = 1 has occurred. Before that first reset edge, pout is undefined (X in simulation).

## Timing
- Latency is 1 cycle. pin sampled at edge N appears on pout immediately after edge N and holds until edge N+1.
- Throughput is one new word per cycle.
- Reset:
  - rst = 1 at an edge forces pout = RST_VAL after that edge, regardless of pin.
  - Asserting rst mid-stream discards the in-flight value; the value present at that edge is lost.
  - Deassertion: the first edge that samples rst = 0 loads pin.
- Changes to pin between edges have no effect on pout.
- Setup and hold on pin and rst are relative to the rising edge of clk only.

## Configuration
- Macro PIPO_ASSERT_EN.
- When defined, the following simulation-only checks are compiled in:
  - after any edge with rst = 1, pout equals RST_VAL;
  - after any edge with rst = 0, pout equals the value of pin sampled at that edge;
  - pout contains no X or Z once the first reset has occurred.
- A failing check reports an error message including the simulation time.
- When not defined, no checks are present. The synthesized logic is identical in both cases.

## Structure
- Shared package pipo_pkg holds the constant PIPO_DEFAULT_WIDTH = 4. The WIDTH parameter default refers to it.
- No sub-module is needed. The block is a single always block on the clk edge plus an output assign.
- Assertion code sits in one `ifdef PIPO_ASSERT_EN` region at the end of the module.

## Test plan
- Reset hold: rst = 1 for 3 edges with pin = 4'b1111 -> pout = 4'b0000 after each edge.
- Stream: after reset release, apply pin = 0001, 0010, 0011, 0100, 1000, 1010, 1001, 1100, one value per cycle -> pout shows the same sequence, each value one cycle after it is applied.
- Mid-cycle glitch: pin toggles between 0101 and 1010 between edges and is stable at 0110 at the edge -> pout = 0110 only.
- Reset mid-stream: with pout = 1010, assert rst for 1 edge while pin = 1001 -> pout = 0000; then deassert with pin = 1100 -> pout = 1100 after the next edge.
- Parameterization: WIDTH = 8, RST_VAL = 8'hA5, reset -> pout = 8'hA5; then pin = 8'h3C -> pout = 8'h3C one cycle later.
- With PIPO_ASSERT_EN defined, run all of the above -> zero assertion failures.
